prga_bram_arbiter: RTL
======================

# prga_bram_arbiter

Shares one dual-port block-RAM instance between NUM_REQ requesters inside the PRGA fabric's memory tile. The RAM is the techmapped `dual_port_ram` column: port 1 is write-only, and port 2 is read-only with `we2` tied low. The block runs two independent round-robin arbiters, one granting writes onto port 1 and one granting reads onto port 2. It registers the memory-side signals, returns read data to the issuing requester, resolves same-address read/write collisions, and can optionally zero-fill the RAM after reset.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width.
- NUM_REQ, 4, number of requesters; minimum 2.

Ports:
- clk  in  1  single clock, shared with the RAM.
- rst  in  1  asynchronous, active-high reset.
- req_val  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed; requester i occupies slice i.
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_rdy  out  NUM_REQ  grant; a transfer occurs when val and rdy are both high.
- resp_val  out  NUM_REQ  one-hot read-data-valid pulse.
- resp_data  out  DATA_WIDTH  read data, shared by all requesters.
- mem_addr1  out  ADDR_WIDTH  RAM port-1 address.
- mem_we1  out  1  RAM port-1 write enable.
- mem_data1  out  DATA_WIDTH  RAM port-1 write data.
- mem_addr2  out  ADDR_WIDTH  RAM port-2 address.
- mem_out2  in  DATA_WIDTH  RAM port-2 read data, registered inside the RAM.
- init_done  out  1  high once the block is in RUN.

## Operation
State machine:
- States are INIT and RUN.
- Reset enters INIT when `PRGA_BRAM_ARB_INIT_EN` is defined, and RUN otherwise.
- INIT moves to RUN after the sweep covers the last address.

Arbitration (RUN state):
- Write candidates: val & we.
- Read candidates: val & ~we.
- Each class has its own round-robin pointer.
- The winner is the first candidate at or above the pointer, wrapping around.
- After a grant, the pointer becomes (winner+1) mod NUM_REQ. With no grant, the pointer holds.
- At most one write grant and one read grant per cycle. Both may go to different requesters in the same cycle.
- `req_rdy` is combinational from `req_val`, `req_we` and the pointers. It is 0 for requesters without a request.

Collision rule:
- If the read winner's address equals the write winner's address in the same cycle, the read is not granted: its rdy is 0 and the read pointer holds.
- The read retries next cycle and so observes the new data.
- Repeated same-address writes may stall that read indefinitely; this is accepted.

Read return:
- The granted read's index is carried in a 2-stage valid/index pipeline.
- `resp_val[idx]` pulses with `resp_data = mem_out2`.

INIT state:
- `req_rdy` is all 0.
- A sweep counter drives `mem_we1=1`, `mem_data1=0` and `mem_addr1=counter`, counting 0 up to 2^ADDR_WIDTH-1.
- Port 2 is idle.

## Timing
Reset values:
- `req_rdy`, `resp_val`, `mem_we1` and `init_done` are 0.
- `mem_addr1`, `mem_data1`, `mem_addr2` and `resp_data` are 0.
- Both round-robin pointers, the sweep counter and the read pipeline are 0.

Latencies:
- A write granted in cycle T has `mem_we1`, `mem_addr1` and `mem_data1` registered and valid in T+1.
- A read granted in cycle T has `mem_addr2` valid in T+1 and `mem_out2` captured at the end of T+1. `resp_val` and `resp_data` are valid in T+2 for exactly one cycle.
- Read throughput: one read per cycle, fully pipelined.
- `mem_we1` is low in any cycle following a cycle with no write grant.

Sweep timing:
- The sweep lasts 2^ADDR_WIDTH cycles. The first sweep write is in the first cycle after reset deassertion.
- `init_done` rises in the cycle after the last sweep write. Requests are granted from that cycle onward.

Reset mid-operation:
- The read pipeline is flushed and no `resp_val` is emitted.
- An in-flight write registered in that cycle is dropped.

## Configuration
- `PRGA_BRAM_ARB_INIT_EN` defined: the INIT zero-fill sweep is compiled in. `init_done` first rises 2^ADDR_WIDTH+1 cycles after reset release.
- Not defined: no sweep counter is built. The block enters RUN straight from reset, `init_done` rises 1 cycle after reset release, and RAM contents are undefined until written.

## Structure
- Package `prga_bram_arb_pkg` holds:
  - the state enum {ARB_INIT, ARB_RUN};
  - the read-pipeline depth constant (2);
  - a one-hot-to-index function.
- Sub-module `prga_rr_arbiter` (parameter NUM_REQ):
  - inputs are the request vector, an enable and a stall;
  - outputs are a one-hot grant and the winner index;
  - it owns its own pointer register.
- `prga_rr_arbiter` is instantiated twice, once for writes and once for reads. The read instance's stall comes from the collision compare.

## Test plan
- Sweep (macro on, ADDR_WIDTH=4): release reset, then read address 5. `init_done` rises on cycle 17, the read returns `resp_data=0`, and `req_rdy` is 0 for cycles 1-16.
- Write then read: requester 1 writes 0xDEADBEEF to address 0x3A in cycle T, and requester 2 reads 0x3A in T+1. `resp_val=4'b0100` with `resp_data=0xDEADBEEF` in T+3.
- Fairness: all 4 requesters hold read requests continuously. Grants rotate 0,1,2,3,0 and each requester receives one `resp_val` every 4 cycles.
- Collision: requester 0 writes 0x55 to address 7 while requester 3 reads address 7 in the same cycle. The read is denied that cycle, granted the next, and returns 0x55. The write is unaffected.
- Concurrent: requester 0 writes address 1 and requester 1 reads address 2 in the same cycle. Both are granted, `mem_we1` and `mem_addr2` are active in T+1, and the read response arrives in T+2.
- Reset during read: assert `rst` in T+1 after a read grant in T. No `resp_val` is seen, and all outputs are 0 while `rst` is high.

Source files
------------

// File: rtl/prga_bram_arb_pkg.sv
// Shared types and helpers for the PRGA memory-tile BRAM arbiter.
// Optional zero-fill sweep is enabled by defining PRGA_BRAM_ARB_INIT_EN.
package prga_bram_arb_pkg;

    typedef enum logic {
        ARB_INIT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_e;

    // Read return: one stage for the address register, one for the RAM output register.
    localparam int RD_PIPE_DEPTH = 2;

    // Upper bound on requesters handled by onehot_to_idx.
    localparam int MAX_REQ   = 32;
    localparam int MAX_IDX_W = 5;

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prga_rr_arbiter.sv
// Round-robin arbiter with its own pointer: the winner is the first request
// at or above the pointer (wrapping); the pointer moves past the winner on a grant.
module prga_rr_arbiter
    import prga_bram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic               stall,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] winner_oh;
    logic               found;

    always_comb begin
        winner_oh = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                winner_oh[cand] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    // idx reports the would-be winner even when stalled, so the caller can
    // inspect that requester's address before deciding to stall.
    assign idx   = IDX_W'(onehot_to_idx(MAX_REQ'(winner_oh)));
    assign grant = (en && !stall) ? winner_oh : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/prga_bram_arbiter.sv
// Shares one write-port/read-port BRAM between NUM_REQ requesters using two
// round-robin arbiters. Define PRGA_BRAM_ARB_INIT_EN to zero-fill the RAM after reset.
module prga_bram_arbiter
    import prga_bram_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH = 10,
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_val,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [NUM_REQ-1:0]            resp_val,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ADDR_WIDTH-1:0]         mem_addr1,
    output logic                          mem_we1,
    output logic [DATA_WIDTH-1:0]         mem_data1,
    output logic [ADDR_WIDTH-1:0]         mem_addr2,
    input  logic [DATA_WIDTH-1:0]         mem_out2,
    output logic                          init_done
);

    localparam int LAST = RD_PIPE_DEPTH - 1;

`ifdef PRGA_BRAM_ARB_INIT_EN
    localparam arb_state_e RESET_STATE = ARB_INIT;
    logic [ADDR_WIDTH:0] sweep_cnt;
`else
    localparam arb_state_e RESET_STATE = ARB_RUN;
`endif

    arb_state_e state;

    logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_a [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_a[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_a[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [NUM_REQ-1:0] wr_req, rd_req, wr_grant, rd_grant;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               collide;
    logic               run;

    assign wr_req = req_val & req_we;
    assign rd_req = req_val & ~req_we;
    // init_done is only set once the block is in RUN, and is low in reset.
    assign run    = init_done;

    // A read hitting the address being written this cycle waits one cycle so
    // it returns the freshly written data.
    assign collide = (|wr_req) && (|rd_req) && (addr_a[rd_idx] == addr_a[wr_idx]);

    prga_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (wr_req),
        .en    (run),
        .stall (1'b0),
        .grant (wr_grant),
        .idx   (wr_idx)
    );

    prga_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (rd_req),
        .en    (run),
        .stall (collide),
        .grant (rd_grant),
        .idx   (rd_idx)
    );

    // Handshake: a transfer happens in any cycle where req_val[i] and req_rdy[i] are both high.
    assign req_rdy = wr_grant | rd_grant;

    logic [RD_PIPE_DEPTH-1:0] pipe_val;
    logic [IDX_W-1:0]         pipe_idx [RD_PIPE_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_STATE;
            init_done <= 1'b0;
            mem_we1   <= 1'b0;
            mem_addr1 <= '0;
            mem_data1 <= '0;
            mem_addr2 <= '0;
            pipe_val  <= '0;
            for (int i = 0; i < RD_PIPE_DEPTH; i++) begin
                pipe_idx[i] <= '0;
            end
`ifdef PRGA_BRAM_ARB_INIT_EN
            sweep_cnt <= '0;
`endif
        end else begin
            case (state)
                ARB_INIT: begin
`ifdef PRGA_BRAM_ARB_INIT_EN
                    // The extra counter bit marks that the last address has been written.
                    if (sweep_cnt[ADDR_WIDTH]) begin
                        state     <= ARB_RUN;
                        init_done <= 1'b1;
                        mem_we1   <= 1'b0;
                    end else begin
                        mem_we1   <= 1'b1;
                        mem_addr1 <= sweep_cnt[ADDR_WIDTH-1:0];
                        mem_data1 <= '0;
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
`else
                    state <= ARB_RUN;
`endif
                end
                default: begin
                    init_done <= 1'b1;
                    mem_we1   <= |wr_grant;
                    if (|wr_grant) begin
                        mem_addr1 <= addr_a[wr_idx];
                        mem_data1 <= data_a[wr_idx];
                    end
                    if (|rd_grant) begin
                        mem_addr2 <= addr_a[rd_idx];
                    end
                end
            endcase

            pipe_val    <= {pipe_val[RD_PIPE_DEPTH-2:0], |rd_grant};
            pipe_idx[0] <= rd_idx;
            for (int i = 1; i < RD_PIPE_DEPTH; i++) begin
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    always_comb begin
        resp_val = '0;
        if (pipe_val[LAST]) begin
            resp_val[pipe_idx[LAST]] = 1'b1;
        end
    end

    assign resp_data = pipe_val[LAST] ? mem_out2 : '0;

endmodule
